// File: rtl/sine_sweep_pkg.sv
// sine_sweep_pkg
//   Shared definitions for the stepped-frequency sine sweep controller:
//   FSM state encoding and default width constants.
package sine_sweep_pkg;

   localparam int unsigned DEF_ACC_WIDTH   = 24;
   localparam int unsigned DEF_PHASE_WIDTH = 8;
   localparam int unsigned DEF_STEPS_WIDTH = 8;
   localparam int unsigned DEF_DWELL_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sweep_state_t;

endpackage

// File: rtl/sine_sweep_ctrl_phase_acc.sv
// phase_acc
//   Modular phase accumulator with clear and enable.  Clear has priority
//   over enable; when neither is asserted the accumulator holds.
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - synchronous active-low reset (accumulator -> 0)
//   i_clr  - load accumulator with 0 on the next edge
//   i_en   - add i_ftw to the accumulator on the next edge
//   i_ftw  - frequency tuning word
//   o_acc  - current accumulator value
module phase_acc
   import sine_sweep_pkg::*;
#(
   parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_clr,
   input  logic                 i_en,
   input  logic [ACC_WIDTH-1:0] i_ftw,
   output logic [ACC_WIDTH-1:0] o_acc
);

   logic [ACC_WIDTH-1:0] acc_q;
   logic [ACC_WIDTH-1:0] acc_d;

   always_comb begin
      acc_d = acc_q;
      if (i_clr) begin
         acc_d = '0;
      end else if (i_en) begin
         acc_d = acc_q + i_ftw;   // wraps modulo 2^ACC_WIDTH
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign o_acc = acc_q;

endmodule

// File: rtl/sine_sweep_ctrl.sv
// sine_sweep_ctrl
//   Stepped-frequency sweep controller for the sine LUT.  Runs a phase
//   accumulator, steps the FTW through n_steps steps of dwell cycles each,
//   and drives the LUT phase/enable.
// Ports:
//   i_clk, i_rst       - clock (rising edge), synchronous active-low reset
//   i_start, i_abort   - start pulse (IDLE only), abort to IDLE (no done)
//   i_ftw_start        - FTW of step 0
//   i_ftw_step         - FTW increment per step (modular)
//   i_n_steps          - number of steps (0 -> immediate done)
//   i_dwell            - cycles per step (0 treated as 1)
//   o_phase            - top PHASE_WIDTH bits of the accumulator
//   o_lut_en           - high in RUN
//   o_busy             - high in RUN and DONE
//   o_step_stb         - pulse on the first RUN cycle of each step
//   o_step_idx         - current step index
//   o_done             - pulse on sweep completion
module sine_sweep_ctrl
   import sine_sweep_pkg::*;
#(
   parameter int unsigned ACC_WIDTH   = DEF_ACC_WIDTH,
   parameter int unsigned PHASE_WIDTH = DEF_PHASE_WIDTH,
   parameter int unsigned STEPS_WIDTH = DEF_STEPS_WIDTH,
   parameter int unsigned DWELL_WIDTH = DEF_DWELL_WIDTH
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_start,
   input  logic                   i_abort,
   input  logic [ACC_WIDTH-1:0]   i_ftw_start,
   input  logic [ACC_WIDTH-1:0]   i_ftw_step,
   input  logic [STEPS_WIDTH-1:0] i_n_steps,
   input  logic [DWELL_WIDTH-1:0] i_dwell,
   output logic [PHASE_WIDTH-1:0] o_phase,
   output logic                   o_lut_en,
   output logic                   o_busy,
   output logic                   o_step_stb,
   output logic [STEPS_WIDTH-1:0] o_step_idx,
   output logic                   o_done
);

   sweep_state_t           state_q,     state_d;
   logic [ACC_WIDTH-1:0]   ftw_q,       ftw_d;
   logic [ACC_WIDTH-1:0]   ftw_step_q,  ftw_step_d;
   logic [STEPS_WIDTH-1:0] n_steps_q,   n_steps_d;
   logic [DWELL_WIDTH-1:0] dwell_m1_q,  dwell_m1_d;
   logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
   logic [STEPS_WIDTH-1:0] step_q,      step_d;
   logic                   stb_q,       stb_d;

   logic                   acc_clr;
   logic                   acc_en;
   logic [ACC_WIDTH-1:0]   acc;

   logic                   step_end;
   logic                   last_step;

   assign step_end  = (dwell_cnt_q == dwell_m1_q);
   assign last_step = (step_q == (n_steps_q - STEPS_WIDTH'(1)));

   always_comb begin
      state_d     = state_q;
      ftw_d       = ftw_q;
      ftw_step_d  = ftw_step_q;
      n_steps_d   = n_steps_q;
      dwell_m1_d  = dwell_m1_q;
      dwell_cnt_d = dwell_cnt_q;
      step_d      = step_q;
      stb_d       = 1'b0;
      acc_clr     = 1'b0;
      acc_en      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Abort outranks start, so start+abort together stays in IDLE.
            if (i_start && !i_abort) begin
               ftw_step_d = i_ftw_step;
               n_steps_d  = i_n_steps;
               // Store dwell-1 so the end-of-step test is a plain compare;
               // a dwell of 0 collapses onto 1.
               dwell_m1_d = (i_dwell == '0) ? '0 : (i_dwell - DWELL_WIDTH'(1));
               if (i_n_steps != '0) begin
                  state_d     = ST_RUN;
                  ftw_d       = i_ftw_start;
                  step_d      = '0;
                  dwell_cnt_d = '0;
                  stb_d       = 1'b1;
                  acc_clr     = 1'b1;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end

         ST_RUN: begin
            if (i_abort) begin
               state_d = ST_IDLE;   // acc and ftw hold
            end else begin
               acc_en = 1'b1;
               if (step_end) begin
                  if (last_step) begin
                     state_d = ST_DONE;
                  end else begin
                     step_d      = step_q + STEPS_WIDTH'(1);
                     ftw_d       = ftw_q + ftw_step_q;
                     dwell_cnt_d = '0;
                     stb_d       = 1'b1;
                  end
               end else begin
                  dwell_cnt_d = dwell_cnt_q + DWELL_WIDTH'(1);
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q     <= ST_IDLE;
         ftw_q       <= '0;
         ftw_step_q  <= '0;
         n_steps_q   <= '0;
         dwell_m1_q  <= '0;
         dwell_cnt_q <= '0;
         step_q      <= '0;
         stb_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ftw_q       <= ftw_d;
         ftw_step_q  <= ftw_step_d;
         n_steps_q   <= n_steps_d;
         dwell_m1_q  <= dwell_m1_d;
         dwell_cnt_q <= dwell_cnt_d;
         step_q      <= step_d;
         stb_q       <= stb_d;
      end
   end

   // The accumulator is fed the FTW that will be in force next cycle, so
   // the increment landing on the first cycle of a new step already uses
   // that step's FTW (phase advances by the new rate without a lag cycle).
   phase_acc #(
      .ACC_WIDTH (ACC_WIDTH)
   ) u_phase_acc (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (acc_clr),
      .i_en  (acc_en),
      .i_ftw (ftw_d),
      .o_acc (acc)
   );

   assign o_phase    = acc[ACC_WIDTH-1 -: PHASE_WIDTH];
   assign o_lut_en   = (state_q == ST_RUN);
   assign o_busy     = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign o_done     = (state_q == ST_DONE);
   assign o_step_stb = stb_q;
   assign o_step_idx = step_q;

endmodule
